// File: rtl/tensor_product_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tensor_product_arbiter
// Description : Shares one tensor_product datapath between two requesters.
//               Each job: round-robin grant, operand capture, one-cycle start
//               pulse, fixed-latency wait timed by an internal tile counter,
//               then result/error capture and a done pulse to the owner.
// Ports       : clk, rst (async, active-low)
//               req0/req1, a0/a1, b0/b1   requester side inputs
//               ack0/ack1, done0/done1     per-requester handshake pulses
//               result, error, busy        shared job outputs
//               tp_rst, tp_start, tp_a/tp_b datapath control and operands
//               tp_result, tp_error        datapath outputs
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_product_arbiter #(
    parameter int A_VECTOR_LEN      = 5,
    parameter int B_VECTOR_LEN      = 5,
    parameter int A_CELL_WIDTH      = 8,
    parameter int B_CELL_WIDTH      = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int TILING_H          = 1,
    parameter int TILING_V          = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            req0,
    input  logic                                            req1,
    input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]            a0,
    input  logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]            a1,
    input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]            b0,
    input  logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]            b1,
    output logic                                            ack0,
    output logic                                            ack1,
    output logic                                            done0,
    output logic                                            done1,
    output logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
    output logic                                            error,
    output logic                                            busy,
    output logic                                            tp_rst,
    output logic                                            tp_start,
    output logic [A_VECTOR_LEN*A_CELL_WIDTH-1:0]            tp_a,
    output logic [B_VECTOR_LEN*B_CELL_WIDTH-1:0]            tp_b,
    input  logic [A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH-1:0] tp_result,
    input  logic                                            tp_error
);

    localparam int AW    = A_VECTOR_LEN * A_CELL_WIDTH;
    localparam int BW    = B_VECTOR_LEN * B_CELL_WIDTH;
    localparam int RW    = A_VECTOR_LEN * B_VECTOR_LEN * RESULT_CELL_WIDTH;
    localparam int TILES = ((A_VECTOR_LEN + TILING_V - 1) / TILING_V) *
                           ((B_VECTOR_LEN + TILING_H - 1) / TILING_H);
    localparam int CW    = $clog2(TILES + 1);

    localparam logic [CW-1:0] C_TILES = CW'(TILES);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            owner_q;
    logic            last_q;
    logic            rel_q;
    logic            tp_rst_q;
    logic            ack0_q;
    logic            ack1_q;
    logic            done0_q;
    logic            done1_q;
    logic            busy_q;
    logic            tp_start_q;
    logic [AW-1:0]   tp_a_q;
    logic [BW-1:0]   tp_b_q;
    logic [RW-1:0]   result_q;
    logic            error_q;

    logic            win_d;
    logic            grant_d;

    // Round-robin: on a tie the requester not granted last wins.
    // No grant while the datapath is still held in reset.
    always_comb begin
        win_d   = (req0 && req1) ? ~last_q : req1;
        grant_d = (state_q == ST_IDLE) && !tp_rst_q && (req0 || req1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            rel_q      <= 1'b0;
            tp_rst_q   <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            busy_q     <= 1'b0;
            tp_start_q <= 1'b0;
            tp_a_q     <= '0;
            tp_b_q     <= '0;
            result_q   <= '0;
            error_q    <= 1'b0;
        end else begin
            // Two-stage release: tp_rst falls on the second edge after rst
            // rises so the datapath drops any stale RUN before a start.
            rel_q      <= 1'b1;
            tp_rst_q   <= ~rel_q;

            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            tp_start_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (grant_d) begin
                        state_q    <= ST_START;
                        owner_q    <= win_d;
                        last_q     <= win_d;
                        tp_a_q     <= win_d ? a1 : a0;
                        tp_b_q     <= win_d ? b1 : b0;
                        ack0_q     <= ~win_d;
                        ack1_q     <= win_d;
                        tp_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= C_TILES;
                end
                ST_WAIT: begin
                    // Leaving on the last count puts CAPTURE one edge after
                    // the datapath writes its final tile.
                    cnt_q <= cnt_q - C_ONE;
                    if (cnt_q == C_ONE) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    result_q <= tp_result;
                    error_q  <= tp_error;
                    done0_q  <= ~owner_q;
                    done1_q  <= owner_q;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign result   = result_q;
    assign error    = error_q;
    assign busy     = busy_q;
    assign tp_rst   = tp_rst_q;
    assign tp_start = tp_start_q;
    assign tp_a     = tp_a_q;
    assign tp_b     = tp_b_q;

endmodule
`default_nettype wire

// File: tb/tb_tensor_product_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tensor_product_arbiter
// Description : Self-checking bench for tensor_product_arbiter with a
//               behavioural tensor_product datapath (Q4.4 cells, one tile
//               per cycle) and an expected-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_product_arbiter;

    localparam int AL    = 5;
    localparam int BL    = 5;
    localparam int AW    = AL * 8;
    localparam int BW    = BL * 8;
    localparam int RW    = AL * BL * 8;
    localparam int TILES = AL * BL;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          req0 = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] a0   = '0;
    logic [AW-1:0] a1   = '0;
    logic [BW-1:0] b0   = '0;
    logic [BW-1:0] b1   = '0;
    logic          ack0, ack1, done0, done1, error, busy, tp_rst, tp_start;
    logic [RW-1:0] result;
    logic [AW-1:0] tp_a;
    logic [BW-1:0] tp_b;
    logic [RW-1:0] tp_result = '0;
    logic          tp_error  = 1'b0;

    typedef struct {
        logic          id;
        logic [RW-1:0] res;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tensor_product_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
        .ack0      (ack0),
        .ack1      (ack1),
        .done0     (done0),
        .done1     (done1),
        .result    (result),
        .error     (error),
        .busy      (busy),
        .tp_rst    (tp_rst),
        .tp_start  (tp_start),
        .tp_a      (tp_a),
        .tp_b      (tp_b),
        .tp_result (tp_result),
        .tp_error  (tp_error)
    );

    // Signed Q4.4 multiply; bit 8 flags a product outside the Q4.4 range.
    function automatic logic [8:0] cell_mul(input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] p;
        logic signed [15:0] s;
        p = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
        s = p >>> 4;
        return {(s > 16'sd127) || (s < -16'sd128), s[7:0]};
    endfunction

    function automatic exp_t make_exp(input logic id, input logic [AW-1:0] a, input logic [BW-1:0] b);
        exp_t       e;
        logic [8:0] c;
        e.id  = id;
        e.err = 1'b0;
        e.res = '0;
        for (int i = 0; i < AL; i++) begin
            for (int j = 0; j < BL; j++) begin
                c = cell_mul(a[i*8 +: 8], b[j*8 +: 8]);
                e.res[(i*BL+j)*8 +: 8] = c[7:0];
                e.err = e.err | c[8];
            end
        end
        return e;
    endfunction

    // Behavioural datapath: start sampled on one edge, then one tile per
    // edge; error clears on start; result stays after completion.
    int         dp_idx = 0;
    logic       dp_run = 1'b0;
    logic [8:0] dp_cell;

    always_comb dp_cell = cell_mul(tp_a[(dp_idx / BL)*8 +: 8], tp_b[(dp_idx % BL)*8 +: 8]);

    always @(posedge clk) begin
        if (tp_rst) begin
            dp_run    <= 1'b0;
            dp_idx    <= 0;
            tp_result <= '0;
            tp_error  <= 1'b0;
        end else if (tp_start) begin
            dp_run    <= 1'b1;
            dp_idx    <= 0;
            tp_result <= '0;
            tp_error  <= 1'b0;
        end else if (dp_run) begin
            tp_result[dp_idx*8 +: 8] <= dp_cell[7:0];
            if (dp_cell[8]) tp_error <= 1'b1;
            dp_idx <= dp_idx + 1;
            if (dp_idx == TILES - 1) dp_run <= 1'b0;
        end
    end

    // Waits up to limit negedges for the chosen signal; n = negedges taken,
    // or -1 if it never appeared. 0=ack0 1=ack1 2=done0 3=done1 4=any ack.
    task automatic wait_for(input int which, input int limit, output int n);
        logic hit;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            case (which)
                0:       hit = ack0;
                1:       hit = ack1;
                2:       hit = done0;
                3:       hit = done1;
                default: hit = ack0 | ack1;
            endcase
            if (hit) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic scoreboard();
        exp_t e;
        forever begin
            @(negedge clk);
            if (done0 || done1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done0=%0b done1=%0b, required no done", done0, done1);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if ({done1, done0} !== {e.id, ~e.id}) begin
                        n_fail++;
                        $display("FAIL sb_done_owner: got {done1,done0}=%b, required %b", {done1, done0}, {e.id, ~e.id});
                    end
                    n_checks++;
                    if (result !== e.res) begin
                        n_fail++;
                        $display("FAIL sb_result: got %h, required %h", result, e.res);
                    end
                    n_checks++;
                    if (error !== e.err) begin
                        n_fail++;
                        $display("FAIL sb_error: got %b, required %b", error, e.err);
                    end
                    n_checks++;
                    if ((ack0 | ack1) !== 1'b0) begin
                        n_fail++;
                        $display("FAIL sb_done_ack_overlap: got ack0=%b ack1=%b with done, required 0", ack0, ack1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        #1 rst = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        a0 = {8'h08, 8'h10, 8'h18, 8'h20, 8'hF0};
        b0 = {8'h10, 8'h20, 8'h08, 8'hE0, 8'h04};
        a1 = {8'h30, 8'h04, 8'h10, 8'hC0, 8'h0C};
        b1 = {8'h02, 8'h10, 8'h40, 8'h06, 8'hF8};
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ack0, ack1, done0, done1, busy, tp_start, tp_rst} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, required 0000001", {ack0, ack1, done0, done1, busy, tp_start, tp_rst});
        end
        n_checks++;
        if ({result, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_result: got %h/%b, required 0/0", result, error);
        end
        n_checks++;
        if ({tp_a, tp_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_operands: got %h %h, required 0", tp_a, tp_b);
        end
        exp_q.push_back(make_exp(1'b0, a0, b0));
        exp_q.push_back(make_exp(1'b1, a1, b1));
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tp_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tp_rst_edge1: got %b, required 1", tp_rst);
        end
        @(negedge clk);
        n_checks++;
        if ({tp_rst, ack0, ack1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_tp_rst_edge2: got tp_rst/ack0/ack1=%b, required 000", {tp_rst, ack0, ack1});
        end
        @(negedge clk);
        n_checks++;
        if ({ack1, ack0} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant: got {ack1,ack0}=%b, required 01", {ack1, ack0});
        end
        req0 = 1'b0;
        wait_for(1, 40, n);
        n_checks++;
        if (n !== TILES + 3) begin
            n_fail++;
            $display("FAIL reset_pending_regrant: got %0d cycles, required %0d", n, TILES + 3);
        end
        req1 = 1'b0;
        wait_for(3, 40, n);
        n_checks++;
        if (n !== TILES + 2) begin
            n_fail++;
            $display("FAIL reset_job1_latency: got %0d cycles, required %0d", n, TILES + 2);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int prev;
        a0 = {8'h10, 8'h10, 8'h20, 8'h08, 8'h18};
        b0 = {8'h04, 8'h08, 8'h10, 8'h20, 8'hF0};
        a1 = {8'hF8, 8'h10, 8'h0C, 8'h14, 8'h02};
        b1 = {8'h10, 8'hF0, 8'h18, 8'h06, 8'h20};
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back(make_exp(1'b0, a0, b0));
            else            exp_q.push_back(make_exp(1'b1, a1, b1));
        end
        req0 = 1'b1;
        req1 = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_for(4, 40, n);
            n_checks++;
            if ({ack1, ack0} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got {ack1,ack0}=%b, required %b", k, {ack1, ack0}, (k % 2 == 1) ? 2'b10 : 2'b01);
            end
            if (k > 0) begin
                n_checks++;
                if (cyc - prev !== TILES + 3) begin
                    n_fail++;
                    $display("FAIL rr_ack_spacing_%0d: got %0d cycles, required %0d", k, cyc - prev, TILES + 3);
                end
            end
            prev = cyc;
            if (k == 2) req0 = 1'b0;
            if (k == 3) req1 = 1'b0;
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d jobs outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_single();
        int n;
        a0 = {5{8'h10}};
        b0 = {5{8'h10}};
        exp_q.push_back(make_exp(1'b0, a0, b0));
        req0 = 1'b1;
        wait_for(0, 10, n);
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL single_ack: got %0d cycles, required 1", n);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_rise: got %b, required 1", busy);
        end
        req0 = 1'b0;
        wait_for(2, 40, n);
        n_checks++;
        if (n !== TILES + 2) begin
            n_fail++;
            $display("FAIL single_latency: got %0d cycles, required %0d", n, TILES + 2);
        end
        n_checks++;
        if (result !== {25{8'h10}} || error !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got %h/%b, required all 10/0", result, error);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_fall: got %b, required 0", busy);
        end
    endtask

    task automatic test_overflow();
        int n;
        a1 = {5{8'h7F}};
        b1 = {5{8'h7F}};
        exp_q.push_back(make_exp(1'b1, a1, b1));
        req1 = 1'b1;
        wait_for(1, 10, n);
        req1 = 1'b0;
        wait_for(3, 40, n);
        n_checks++;
        if (n !== TILES + 2 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_error: got latency %0d error %b, required %0d and 1", n, error, TILES + 2);
        end
        a0 = {5{8'h04}};
        b0 = {5{8'h04}};
        exp_q.push_back(make_exp(1'b0, a0, b0));
        req0 = 1'b1;
        wait_for(0, 10, n);
        req0 = 1'b0;
        wait_for(2, 40, n);
        n_checks++;
        if (n !== TILES + 2 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_clear: got latency %0d error %b, required %0d and 0", n, error, TILES + 2);
        end
    endtask

    task automatic test_stability();
        int            n;
        logic [AW-1:0] sa;
        logic [BW-1:0] sb;
        a0 = {8'h12, 8'h0E, 8'hF4, 8'h1A, 8'h08};
        b0 = {8'h06, 8'h1C, 8'h10, 8'hEC, 8'h22};
        sa = a0;
        sb = b0;
        exp_q.push_back(make_exp(1'b0, a0, b0));
        req0 = 1'b1;
        wait_for(0, 10, n);
        req0 = 1'b0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done0) begin
                n = k;
                break;
            end
            a0 = AW'({$urandom(), $urandom()});
            b0 = BW'({$urandom(), $urandom()});
        end
        n_checks++;
        if (n !== TILES + 2) begin
            n_fail++;
            $display("FAIL stability_latency: got %0d cycles, required %0d", n, TILES + 2);
        end
        n_checks++;
        if ({tp_a, tp_b} !== {sa, sb}) begin
            n_fail++;
            $display("FAIL stability_operands: got %h %h, required %h %h", tp_a, tp_b, sa, sb);
        end
    endtask

    task automatic test_midreset();
        int n;
        a0 = {8'h10, 8'h08, 8'h04, 8'h20, 8'h18};
        b0 = {8'h10, 8'h10, 8'h08, 8'h04, 8'hF8};
        exp_q.push_back(make_exp(1'b0, a0, b0));
        req0 = 1'b1;
        wait_for(0, 10, n);
        req0 = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        #1;
        n_checks++;
        if ({ack0, ack1, done0, done1, busy, tp_start, tp_rst} !== 7'b0000001 ||
            {result, error, tp_a, tp_b} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ctrl %b result %h, required 0000001 and 0",
                     {ack0, ack1, done0, done1, busy, tp_start, tp_rst}, result);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_for(2, 35, n);
        n_checks++;
        if (n !== -1) begin
            n_fail++;
            $display("FAIL midreset_no_done: got done0 after %0d cycles, required none", n);
        end
        a0 = {8'h08, 8'h08, 8'h10, 8'h10, 8'h20};
        b0 = {8'h20, 8'h10, 8'h08, 8'hF0, 8'h04};
        exp_q.push_back(make_exp(1'b0, a0, b0));
        req0 = 1'b1;
        wait_for(0, 10, n);
        req0 = 1'b0;
        n_checks++;
        if (n !== 1) begin
            n_fail++;
            $display("FAIL midreset_regrant: got %0d cycles, required 1", n);
        end
        wait_for(2, 40, n);
        n_checks++;
        if (n !== TILES + 2) begin
            n_fail++;
            $display("FAIL midreset_latency: got %0d cycles, required %0d", n, TILES + 2);
        end
    endtask

    initial begin
        fork
            scoreboard();
        join_none
        test_reset();
        test_round_robin();
        test_single();
        test_overflow();
        test_stability();
        test_midreset();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/tensor_product_arbiter.md
# tensor_product_arbiter

Shares one `tensor_product` datapath between two requesters, e.g. the weight-gradient and error-propagation paths of the backpropagation core. It sequences each job: round-robin grant, operand capture, start pulse, fixed-latency wait and result/error return. Completion is timed by the arbiter's own tile counter, because the datapath's `valid` stays high after its first completion.

## Interface
- `A_VECTOR_LEN`, 5, elements of operand a.
- `B_VECTOR_LEN`, 5, elements of operand b.
- `A_CELL_WIDTH`, 8, bits per a element.
- `B_CELL_WIDTH`, 8, bits per b element.
- `RESULT_CELL_WIDTH`, 8, bits per result cell.
- `TILING_H`, 1, b cells processed per datapath cycle.
- `TILING_V`, 1, a rows processed per datapath cycle.
- Derived: `TILES = ceil(A_VECTOR_LEN/TILING_V) * ceil(B_VECTOR_LEN/TILING_H)`. `RW = A_VECTOR_LEN*B_VECTOR_LEN*RESULT_CELL_WIDTH`.
- `clk`, in, 1, the only clock.
- `rst`, in, 1, asynchronous, active-low reset.
- `req0`, `req1`, in, 1, level request, held until the matching ack.
- `a0`, `a1`, in, `A_VECTOR_LEN*A_CELL_WIDTH`, operand a per requester, sampled on grant.
- `b0`, `b1`, in, `B_VECTOR_LEN*B_CELL_WIDTH`, operand b per requester, sampled on grant.
- `ack0`, `ack1`, out, 1, one-cycle pulse: request accepted, operands captured.
- `done0`, `done1`, out, 1, one-cycle pulse: `result` and `error` are valid for that requester.
- `result`, out, RW, last captured product, held until the next capture.
- `error`, out, 1, overflow flag of the last job, held with `result`.
- `busy`, out, 1, high in every state except IDLE.
- `tp_rst`, out, 1, active-high synchronous reset to the datapath.
- `tp_start`, out, 1, datapath start.
- `tp_a`, out, `A_VECTOR_LEN*A_CELL_WIDTH`, registered operand a to the datapath.
- `tp_b`, out, `B_VECTOR_LEN*B_CELL_WIDTH`, registered operand b to the datapath.
- `tp_result`, in, RW, datapath result.
- `tp_error`, in, 1, datapath error.

## Operation
- States and transitions:
  - IDLE: on any req, grant and go to START.
  - START: `tp_start`=1 for exactly this one cycle, then go to WAIT.
  - WAIT: load counter with `TILES`, decrement each cycle; at 0 go to CAPTURE.
  - CAPTURE: register `tp_result` and `tp_error`, pulse `done` of the owner, go to IDLE.
- Grant:
  - Only one requester asserting: it wins.
  - Both asserting: the one not granted last wins.
  - After reset, `last_grant`=1, so req0 wins a first tie.
- At the grant edge:
  - `tp_a`/`tp_b` load the winner's operands and stay stable until the next grant. The datapath reads them combinationally on every RUN cycle.
  - The owner id is latched.
  - `ack` of the winner pulses for one cycle.
- Request rules:
  - A requester must drop req in the cycle after ack.
  - A req still high when the arbiter returns to IDLE is a new job.
  - The losing req stays pending; the arbiter never drops it.
- Result and error:
  - No arithmetic in the arbiter; `result` is `tp_result` copied bit-exact.
  - `error` is `tp_error` sampled at CAPTURE. The datapath clears its error on start, so `error` covers the current job only.
  - `done` of the non-owner never pulses.
- Reset:
  - While `rst`=0: all state cleared to IDLE, every output 0, `tp_rst`=1.
  - `tp_rst` deasserts synchronously on the second rising edge after `rst` rises, so the datapath leaves any stale RUN before the first start.
  - Reset mid-job: the job is discarded with no done. The requester must re-request.

## Timing
- Grant edge = E0; `ack` is high in cycle E0..E1.
- `tp_start` is high in cycle E0..E1; the datapath samples it at E1.
- The datapath writes tiles at edges E2..E(TILES+1).
- CAPTURE edge is E(TILES+2); `done` is high in cycle E(TILES+2)..E(TILES+3).
- Grant-to-done latency is `TILES`+2 cycles. Back-to-back jobs start every `TILES`+3 cycles.
- The earliest regrant is in the IDLE cycle right after CAPTURE. `done` of job n and `ack` of job n+1 are never in the same cycle.
- `busy` rises the cycle after E0 and falls the cycle after CAPTURE.
- No request is accepted before `tp_rst` falls.

## Test plan
- Reset values: hold `rst`=0 with both reqs high -> every output 0 and `tp_rst`=1. Release -> `tp_rst` falls after 2 edges, then req0 is acked first.
- Single job, defaults (`TILES`=25): req0 with a0=b0={5{8'h10}} (1.0 in Q4.4) -> `ack0` at E0, `done0` exactly 27 cycles later. `result`: all 25 cells 8'h10, `error`=0, `done1` never pulses.
- Tie and round-robin: both reqs held continuously for 4 jobs -> grant order 0,1,0,1. Each `done` goes to the matching owner, with 28 cycles between acks.
- Overflow: req1 with a1=b1={5{8'h7F}} -> `done1` with `error`=1. A following req0 with small operands -> `error`=0.
- Operand stability: change a0/b0 every cycle after `ack0` -> `result` equals the product of the operands sampled at the grant edge.
- Mid-job reset: assert `rst` 10 cycles after `ack0` -> no `done0`, outputs 0. A request after recovery -> correct result after 27 cycles.
